// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register: next-PC select, branch/jalr targets, flush bubbles, redirect/flush counters.
// One-cycle latency from a redirect select to IF_PC; stall or CE=0 freezes everything, and rst overrides both.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CE,
  input  logic        stall,
  input  logic [1:0]  PC_mux_sel,
  input  logic [1:0]  branch_PC_mux1_sel,
  input  logic [1:0]  branch_PC_mux2_sel,
  input  logic        flush_signal,
  input  logic [31:0] IF_instr,
  input  logic [31:0] ID_imm,
  input  logic [31:0] ID_rs1_data,
  output logic [31:0] IF_PC,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_instr,
  output logic        ID_valid,
  output logic [15:0] flush_count,
  output logic [15:0] redirect_count
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t      state, state_nxt;
  logic [31:0] b_imm, j_imm, base, offset, branch_target, jalr_sum, jalr_target;
  logic [31:0] pc_plus4, sel_pc, pc_nxt;
  logic        load, bubble, inc_flush, inc_redir;

  assign b_imm         = {{20{IF_instr[31]}}, IF_instr[7], IF_instr[30:25], IF_instr[11:8], 1'b0};
  assign j_imm         = {{12{IF_instr[31]}}, IF_instr[19:12], IF_instr[20], IF_instr[30:21], 1'b0};
  assign branch_target = base + offset;
  assign jalr_sum      = ID_rs1_data + ID_imm;
  assign jalr_target   = {jalr_sum[31:1], 1'b0};
  assign pc_plus4      = IF_PC + 32'd4;

  always_comb begin
    case (branch_PC_mux1_sel)
      2'b01:   base = ID_PC;
      2'b10:   base = ID_PC + 32'd4;
      default: base = IF_PC;
    endcase
    case (branch_PC_mux2_sel)
      2'b00:   offset = b_imm;
      2'b01:   offset = ID_imm;
      2'b10:   offset = 32'd0;
      default: offset = j_imm;
    endcase
    case (PC_mux_sel)
      2'b00:   sel_pc = pc_plus4;
      2'b01:   sel_pc = branch_target;
      2'b10:   sel_pc = jalr_target;
      default: sel_pc = IF_PC;
    endcase
  end

  // BOOT squashes the first fetched slot so ID never sees a word fetched during reset.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    bubble    = 1'b0;
    inc_flush = 1'b0;
    inc_redir = 1'b0;
    pc_nxt    = IF_PC;
    if (CE) begin
      if (state == BOOT) begin
        state_nxt = RUN;
        load      = 1'b1;
        bubble    = 1'b1;
        pc_nxt    = RESET_PC + 32'd4;
      end else if (!stall) begin
        load      = 1'b1;
        bubble    = flush_signal;
        inc_flush = flush_signal;
        inc_redir = (PC_mux_sel == 2'b01) || (PC_mux_sel == 2'b10);
        pc_nxt    = sel_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= BOOT;
      IF_PC          <= RESET_PC;
      ID_PC          <= 32'd0;
      ID_instr       <= NOP_INSTR;
      ID_valid       <= 1'b0;
      flush_count    <= 16'd0;
      redirect_count <= 16'd0;
    end else begin
      state <= state_nxt;
      if (load) begin
        IF_PC <= pc_nxt;
        if (bubble) begin
          ID_PC    <= 32'd0;
          ID_instr <= NOP_INSTR;
          ID_valid <= 1'b0;
        end else begin
          ID_PC    <= IF_PC;
          ID_instr <= IF_instr;
          ID_valid <= 1'b1;
        end
      end
      if (inc_flush && flush_count != 16'hFFFF)
        flush_count <= flush_count + 16'd1;
      if (inc_redir && redirect_count != 16'hFFFF)
        redirect_count <= redirect_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and random bench for fetch_stage against a cycle-level reference model.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst, CE, stall, flush_signal;
  logic [1:0]  PC_mux_sel, branch_PC_mux1_sel, branch_PC_mux2_sel;
  logic [31:0] IF_instr, ID_imm, ID_rs1_data;
  logic [31:0] IF_PC, ID_PC, ID_instr;
  logic        ID_valid;
  logic [15:0] flush_count, redirect_count;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [31:0] m_if_pc, m_id_pc, m_id_instr;
  logic        m_id_valid, m_booted;
  logic [15:0] m_fc, m_rc;

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .rst(rst), .CE(CE), .stall(stall),
    .PC_mux_sel(PC_mux_sel), .branch_PC_mux1_sel(branch_PC_mux1_sel),
    .branch_PC_mux2_sel(branch_PC_mux2_sel), .flush_signal(flush_signal),
    .IF_instr(IF_instr), .ID_imm(ID_imm), .ID_rs1_data(ID_rs1_data),
    .IF_PC(IF_PC), .ID_PC(ID_PC), .ID_instr(ID_instr), .ID_valid(ID_valid),
    .flush_count(flush_count), .redirect_count(redirect_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    logic [31:0] r;
    r = v;
    for (int k = bits; k < 32; k++) r[k] = v[bits-1];
    return r;
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] i);
    logic [31:0] raw;
    raw = (32'(i[31]) << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
    return sext(raw, 13);
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] i);
    logic [31:0] raw;
    raw = (32'(i[31]) << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
    return sext(raw, 21);
  endfunction

  task automatic model_step();
    logic [31:0] bases [4];
    logic [31:0] offs [4];
    logic [31:0] targets [4];
    if (rst) begin
      m_if_pc = 32'h0; m_id_pc = 32'h0; m_id_instr = 32'h13; m_id_valid = 1'b0;
      m_fc = 16'h0; m_rc = 16'h0; m_booted = 1'b0;
    end else if (CE && !m_booted) begin
      m_id_pc = 32'h0; m_id_instr = 32'h13; m_id_valid = 1'b0;
      m_if_pc = 32'h4; m_booted = 1'b1;
    end else if (CE && !stall) begin
      bases   = '{m_if_pc, m_id_pc, m_id_pc + 32'd4, m_if_pc};
      offs    = '{imm_b(IF_instr), ID_imm, 32'd0, imm_j(IF_instr)};
      targets = '{m_if_pc + 32'd4,
                  bases[branch_PC_mux1_sel] + offs[branch_PC_mux2_sel],
                  (ID_rs1_data + ID_imm) & ~32'd1,
                  m_if_pc};
      if (flush_signal) begin
        m_id_pc = 32'h0; m_id_instr = 32'h13; m_id_valid = 1'b0;
        if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
      end else begin
        m_id_pc = m_if_pc; m_id_instr = IF_instr; m_id_valid = 1'b1;
      end
      if ((PC_mux_sel == 2'd1 || PC_mux_sel == 2'd2) && m_rc != 16'hFFFF) m_rc = m_rc + 16'd1;
      m_if_pc = targets[PC_mux_sel];
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_if_pc"}, IF_PC, m_if_pc);
    chk({tag, "_id_pc"}, ID_PC, m_id_pc);
    chk({tag, "_id_instr"}, ID_instr, m_id_instr);
    chk({tag, "_id_valid"}, 32'(ID_valid), 32'(m_id_valid));
    chk({tag, "_flush_cnt"}, 32'(flush_count), 32'(m_fc));
    chk({tag, "_redir_cnt"}, 32'(redirect_count), 32'(m_rc));
  endtask

  initial begin
    logic [15:0] fc0, rc0;
    m_booted = 1'b0;
    rst = 1'b1; CE = 1'b1; stall = 1'b0; flush_signal = 1'b0;
    PC_mux_sel = 2'd0; branch_PC_mux1_sel = 2'd0; branch_PC_mux2_sel = 2'd0;
    IF_instr = 32'h0; ID_imm = 32'h0; ID_rs1_data = 32'h0;
    tick();
    check_all("reset");
    chk("reset_nop", ID_instr, 32'h0000_0013);

    // sequential fetch out of reset; first slot is the boot bubble
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      IF_instr = $urandom;
      tick();
      check_all("seq");
      chk("seq_pc", IF_PC, 32'(4 * (c + 1)));
      chk("seq_valid", 32'(ID_valid), (c == 0) ? 32'd0 : 32'd1);
    end

    // beq +0x20 taken from 0x100
    PC_mux_sel = 2'd2; ID_rs1_data = 32'h100; ID_imm = 32'h0; IF_instr = $urandom;
    tick(); check_all("jalr_to_100");
    rc0 = m_rc;
    IF_instr = 32'h0200_0063; PC_mux_sel = 2'd1;
    branch_PC_mux1_sel = 2'd0; branch_PC_mux2_sel = 2'd0;
    tick(); check_all("beq");
    chk("beq_pc", IF_PC, 32'h120);
    chk("beq_rc", 32'(redirect_count), 32'(rc0 + 16'd1));
    chk("beq_valid", 32'(ID_valid), 32'd1);

    // flushing redirect to ID_PC+4
    PC_mux_sel = 2'd2; ID_rs1_data = 32'h200; IF_instr = $urandom;
    tick(); check_all("jalr_to_200");
    PC_mux_sel = 2'd0; IF_instr = $urandom;
    tick(); check_all("adv_200");
    fc0 = m_fc;
    flush_signal = 1'b1; PC_mux_sel = 2'd1;
    branch_PC_mux1_sel = 2'd2; branch_PC_mux2_sel = 2'd2; IF_instr = $urandom;
    tick(); check_all("flush");
    chk("flush_pc", IF_PC, 32'h204);
    chk("flush_instr", ID_instr, 32'h0000_0013);
    chk("flush_valid", 32'(ID_valid), 32'd0);
    chk("flush_fc", 32'(flush_count), 32'(fc0 + 16'd1));

    // jalr clears bit 0; then a stall freezes everything
    flush_signal = 1'b0; PC_mux_sel = 2'd2; ID_rs1_data = 32'h1003; ID_imm = 32'h4;
    tick(); check_all("jalr");
    chk("jalr_pc", IF_PC, 32'h1006);
    stall = 1'b1; flush_signal = 1'b1; ID_rs1_data = 32'h2000; IF_instr = $urandom;
    tick(); check_all("stall");
    chk("stall_pc", IF_PC, 32'h1006);
    stall = 1'b0; flush_signal = 1'b0;

    // clock enable low holds state under random control
    CE = 1'b0;
    for (int c = 0; c < 5; c++) begin
      stall = 1'($urandom); flush_signal = 1'($urandom); PC_mux_sel = 2'($urandom);
      branch_PC_mux1_sel = 2'($urandom); branch_PC_mux2_sel = 2'($urandom);
      IF_instr = $urandom; ID_imm = $urandom; ID_rs1_data = $urandom;
      tick(); check_all("ce_low");
    end
    CE = 1'b1; stall = 1'b0; flush_signal = 1'b0;

    // PC+4 wrap
    PC_mux_sel = 2'd2; ID_rs1_data = 32'hFFFF_FFFC; ID_imm = 32'h0;
    tick(); check_all("to_top");
    PC_mux_sel = 2'd0;
    tick(); check_all("wrap");
    chk("wrap_pc", IF_PC, 32'h0);

    // random traffic including resets mid-stall/mid-flush
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 29) == 0);
      CE = ($urandom_range(0, 7) != 0);
      stall = ($urandom_range(0, 3) == 0);
      flush_signal = ($urandom_range(0, 3) == 0);
      PC_mux_sel = 2'($urandom); branch_PC_mux1_sel = 2'($urandom);
      branch_PC_mux2_sel = 2'($urandom);
      IF_instr = $urandom; ID_imm = $urandom; ID_rs1_data = $urandom;
      tick(); check_all("rand");
    end

    // drive both counters into saturation
    rst = 1'b0; CE = 1'b1; stall = 1'b0; flush_signal = 1'b1; PC_mux_sel = 2'd1;
    for (int c = 0; c < 65540; c++) begin
      branch_PC_mux1_sel = 2'($urandom); branch_PC_mux2_sel = 2'($urandom);
      IF_instr = $urandom; ID_imm = $urandom;
      tick();
      if (c % 8192 == 0) check_all("sat_run");
    end
    check_all("sat");
    chk("sat_fc", 32'(flush_count), 32'h0000_FFFF);
    chk("sat_rc", 32'(redirect_count), 32'h0000_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
